// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: RV32I decode plus ID/EX/MEM/WB control pipeline with hazard stall, flush and illegal trap.
// Define PIPE_CTRL_FWD_EN to switch from the stall-only policy to the forwarding policy.
module pipe_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int BE_W = 4,
  parameter bit RF_WRITE_THROUGH = 1'b1,
  localparam int CTRL_W = 17 + BE_W
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [31:0]       ID_INSTR,
  input  logic              ID_VALID,
  input  logic              EX_TAKEN,
  output logic              STALL,
  output logic              FLUSH,
  output logic [CTRL_W-1:0] EX_CTRL,
  output logic [CTRL_W-1:0] MEM_CTRL,
  output logic [CTRL_W-1:0] WB_CTRL,
  output logic [REG_AW-1:0] EX_RD,
  output logic [REG_AW-1:0] MEM_RD,
  output logic [REG_AW-1:0] WB_RD,
  output logic [1:0]        FWD_A,
  output logic [1:0]        FWD_B,
  output logic              ILLEGAL
);
  localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(8'h80);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [3:0] alu_op;
  logic src_a, src_b, jmp, br, ld, mrd, mwen, we, legal, use1, use2;
  logic [1:0] rw, op_src;
  logic [BE_W-1:0] be_sz, mbe;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [REG_AW-1:0] dec_rd, rs1, rs2;
  logic ex_live, mem_live, wb_live, hazard, take;
  logic unused_bits;
  assign opc = ID_INSTR[6:0];
  assign f3 = ID_INSTR[14:12];
  assign unused_bits = ^{ID_INSTR[31], ID_INSTR[29:25]};
  assign be_sz = f3[1:0] == 2'b00 ? BE_W'(4'h1) :
                 f3[1:0] == 2'b01 ? BE_W'(4'h3) :
                 f3[1:0] == 2'b10 ? BE_W'(4'hf) : '0;
  always_comb begin
    alu_op = '0;
    src_a = 1'b0;
    src_b = 1'b0;
    jmp = 1'b0;
    br = 1'b0;
    ld = 1'b0;
    mrd = 1'b0;
    mwen = 1'b1;
    mbe = '0;
    rw = 2'b00;
    op_src = 2'b00;
    we = 1'b0;
    legal = 1'b1;
    use1 = 1'b0;
    use2 = 1'b0;
    case (opc)
      7'b1101111: begin src_b = 1'b1; jmp = 1'b1; we = 1'b1; end
      7'b1100111: begin src_a = 1'b1; src_b = 1'b1; jmp = 1'b1; we = 1'b1; use1 = 1'b1; end
      7'b1100011: begin alu_op = {1'b0, f3}; src_b = 1'b1; br = 1'b1; op_src = 2'b10; use1 = 1'b1; use2 = 1'b1; end
      7'b0000011: begin src_a = 1'b1; src_b = 1'b1; ld = 1'b1; mrd = 1'b1; rw = 2'b01; we = 1'b1; mbe = be_sz; use1 = 1'b1; end
      7'b0100011: begin src_a = 1'b1; src_b = 1'b1; mwen = 1'b0; op_src = 2'b01; mbe = be_sz; use1 = 1'b1; use2 = 1'b1; end
      7'b0010011: begin alu_op = {f3 == 3'b101 && ID_INSTR[30], f3}; src_a = 1'b1; src_b = 1'b1; rw = 2'b10; we = 1'b1; use1 = 1'b1; end
      7'b0110011: begin alu_op = {ID_INSTR[30], f3}; src_a = 1'b1; rw = 2'b10; we = 1'b1; use1 = 1'b1; use2 = 1'b1; end
      7'b0110111: begin rw = 2'b11; we = 1'b1; end
      7'b0010111: begin src_b = 1'b1; rw = 2'b10; we = 1'b1; end
      default: legal = 1'b0;
    endcase
  end
  assign dec_ctrl = {alu_op, src_a, src_b, jmp, br, ld, mbe, mwen, mrd, rw, op_src, we, legal};
  assign dec_rd = we ? REG_AW'(ID_INSTR[11:7]) : '0;
  assign rs1 = use1 ? REG_AW'(ID_INSTR[19:15]) : '0;
  assign rs2 = use2 ? REG_AW'(ID_INSTR[24:20]) : '0;
  assign ex_live = EX_CTRL[0] & EX_CTRL[1];
  assign mem_live = MEM_CTRL[0] & MEM_CTRL[1];
  assign wb_live = WB_CTRL[0] & WB_CTRL[1];
  function automatic logic hit(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rd, input logic live);
    return live && rs != '0 && rs == rd;
  endfunction
`ifdef PIPE_CTRL_FWD_EN
  logic [REG_AW-1:0] ex_rs1, ex_rs2;
  function automatic logic [1:0] fwd(input logic [REG_AW-1:0] rs);
    return hit(rs, MEM_RD, mem_live) ? 2'b01 : hit(rs, WB_RD, wb_live) ? 2'b10 : 2'b00;
  endfunction
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      ex_rs1 <= '0;
      ex_rs2 <= '0;
    end else begin
      ex_rs1 <= take ? rs1 : '0;
      ex_rs2 <= take ? rs2 : '0;
    end
  // Only a load still in EX cannot be forwarded in time.
  assign hazard = EX_CTRL[8+BE_W] && (hit(rs1, EX_RD, ex_live) || hit(rs2, EX_RD, ex_live));
  assign FWD_A = fwd(ex_rs1);
  assign FWD_B = fwd(ex_rs2);
`else
  assign hazard = hit(rs1, EX_RD, ex_live) || hit(rs2, EX_RD, ex_live) ||
                  hit(rs1, MEM_RD, mem_live) || hit(rs2, MEM_RD, mem_live) ||
                  (!RF_WRITE_THROUGH && (hit(rs1, WB_RD, wb_live) || hit(rs2, WB_RD, wb_live)));
  assign FWD_A = 2'b00;
  assign FWD_B = 2'b00;
`endif
  assign FLUSH = EX_TAKEN;
  assign STALL = ID_VALID && !EX_TAKEN && hazard;
  assign take = ID_VALID && !FLUSH && !STALL;
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      EX_CTRL <= BUBBLE;
      MEM_CTRL <= BUBBLE;
      WB_CTRL <= BUBBLE;
      EX_RD <= '0;
      MEM_RD <= '0;
      WB_RD <= '0;
      ILLEGAL <= 1'b0;
    end else begin
      EX_CTRL <= take ? dec_ctrl : BUBBLE;
      EX_RD <= take ? dec_rd : '0;
      MEM_CTRL <= EX_CTRL;
      MEM_RD <= EX_RD;
      WB_CTRL <= MEM_CTRL;
      WB_RD <= MEM_RD;
      ILLEGAL <= ILLEGAL | (ID_VALID & ~EX_TAKEN & ~legal);
    end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed checks of decode, hazards, flush, illegal trap and async reset.
module tb_pipe_ctrl_unit;
  localparam logic [20:0] BUB = 21'h000080;
  localparam logic [20:0] ADD_B = 21'h0100A3;
  localparam logic [20:0] SUB_B = 21'h1100A3;
  localparam logic [20:0] LUI_B = 21'h0000B3;
  localparam logic [20:0] SRAI_B = 21'h1B80A3;
  localparam logic [20:0] LW_B = 21'h019FD3;
  localparam logic [20:0] ADDI_B = 21'h0180A3;
  localparam logic [20:0] SB_B = 21'h018105;
`ifdef PIPE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic CLK, RSTn, ID_VALID, EX_TAKEN;
  logic [31:0] ID_INSTR;
  logic STALL, FLUSH, ILLEGAL, n_stall, n_flush, n_ill;
  logic [20:0] EX_CTRL, MEM_CTRL, WB_CTRL, n_ex, n_mem, n_wb;
  logic [4:0] EX_RD, MEM_RD, WB_RD, n_exrd, n_memrd, n_wbrd;
  logic [1:0] FWD_A, FWD_B, n_fa, n_fb;
  int errors = 0;
  int checks = 0;

  pipe_ctrl_unit dut (
    .CLK(CLK), .RSTn(RSTn), .ID_INSTR(ID_INSTR), .ID_VALID(ID_VALID), .EX_TAKEN(EX_TAKEN),
    .STALL(STALL), .FLUSH(FLUSH), .EX_CTRL(EX_CTRL), .MEM_CTRL(MEM_CTRL), .WB_CTRL(WB_CTRL),
    .EX_RD(EX_RD), .MEM_RD(MEM_RD), .WB_RD(WB_RD), .FWD_A(FWD_A), .FWD_B(FWD_B), .ILLEGAL(ILLEGAL)
  );
  pipe_ctrl_unit #(.RF_WRITE_THROUGH(1'b0)) dut_nwt (
    .CLK(CLK), .RSTn(RSTn), .ID_INSTR(ID_INSTR), .ID_VALID(ID_VALID), .EX_TAKEN(EX_TAKEN),
    .STALL(n_stall), .FLUSH(n_flush), .EX_CTRL(n_ex), .MEM_CTRL(n_mem), .WB_CTRL(n_wb),
    .EX_RD(n_exrd), .MEM_RD(n_memrd), .WB_RD(n_wbrd), .FWD_A(n_fa), .FWD_B(n_fb), .ILLEGAL(n_ill)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task step;
    @(posedge CLK);
    #1;
  endtask

  task idle(input int n);
    ID_VALID = 1'b0;
    EX_TAKEN = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task test_reset;
    RSTn = 1'b0;
    ID_VALID = 1'b0;
    EX_TAKEN = 1'b0;
    ID_INSTR = 32'h0;
    step();
    step();
    checks++; if (EX_CTRL !== BUB) begin errors++; $display("FAIL reset_ex got %h exp %h", EX_CTRL, BUB); end
    checks++; if (WB_CTRL !== BUB) begin errors++; $display("FAIL reset_wb got %h exp %h", WB_CTRL, BUB); end
    checks++; if (STALL !== 1'b0 || FLUSH !== 1'b0 || ILLEGAL !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b%b exp 000", STALL, FLUSH, ILLEGAL); end
    checks++; if (FWD_A !== 2'b00 || FWD_B !== 2'b00) begin errors++; $display("FAIL reset_fwd got %b %b exp 00 00", FWD_A, FWD_B); end
    RSTn = 1'b1;
    step();
    checks++; if (EX_CTRL !== BUB || EX_RD !== 5'd0) begin errors++; $display("FAIL post_reset_ex got %h/%0d exp %h/0", EX_CTRL, EX_RD, BUB); end
  endtask

  task test_decode_alu;
    ID_VALID = 1'b1;
    ID_INSTR = 32'h002081B3;
    #1;
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL add_stall got %b exp 0", STALL); end
    step();
    checks++; if (EX_CTRL !== ADD_B || EX_RD !== 5'd3) begin errors++; $display("FAIL add_ex got %h/%0d exp %h/3", EX_CTRL, EX_RD, ADD_B); end
    ID_INSTR = 32'h402081B3;
    step();
    checks++; if (EX_CTRL !== SUB_B || EX_RD !== 5'd3) begin errors++; $display("FAIL sub_ex got %h/%0d exp %h/3", EX_CTRL, EX_RD, SUB_B); end
    checks++; if (MEM_CTRL !== ADD_B) begin errors++; $display("FAIL add_mem got %h exp %h", MEM_CTRL, ADD_B); end
    ID_INSTR = 32'h000003B7;
    step();
    checks++; if (EX_CTRL !== LUI_B || EX_RD !== 5'd7) begin errors++; $display("FAIL lui_ex got %h/%0d exp %h/7", EX_CTRL, EX_RD, LUI_B); end
    checks++; if (WB_CTRL !== ADD_B || WB_RD !== 5'd3) begin errors++; $display("FAIL add_wb got %h/%0d exp %h/3", WB_CTRL, WB_RD, ADD_B); end
    ID_INSTR = 32'h4010D093;
    step();
    checks++; if (EX_CTRL !== SRAI_B || EX_RD !== 5'd1) begin errors++; $display("FAIL srai_ex got %h/%0d exp %h/1", EX_CTRL, EX_RD, SRAI_B); end
    idle(4);
  endtask

  task test_load_use;
    ID_VALID = 1'b1;
    ID_INSTR = 32'h0000A283;
    step();
    checks++; if (EX_CTRL !== LW_B || EX_RD !== 5'd5) begin errors++; $display("FAIL lw_ex got %h/%0d exp %h/5", EX_CTRL, EX_RD, LW_B); end
    ID_INSTR = 32'h00528333;
    for (int i = 0; i < (FWD ? 1 : 2); i++) begin
      #1;
      checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL lu_stall%0d got %b exp 1", i, STALL); end
      step();
      checks++; if (EX_CTRL !== BUB) begin errors++; $display("FAIL lu_bubble%0d got %h exp %h", i, EX_CTRL, BUB); end
    end
    #1;
    checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", STALL); end
    step();
    checks++; if (EX_CTRL !== ADD_B || EX_RD !== 5'd6) begin errors++; $display("FAIL lu_add_ex got %h/%0d exp %h/6", EX_CTRL, EX_RD, ADD_B); end
    checks++; if (FWD_A !== (FWD ? 2'b10 : 2'b00) || FWD_B !== (FWD ? 2'b10 : 2'b00)) begin errors++; $display("FAIL lu_fwd got %b %b exp %b", FWD_A, FWD_B, FWD ? 2'b10 : 2'b00); end
    idle(4);
  endtask

  task test_raw;
    int ns, nn;
    ns = 0;
    nn = 0;
    ID_VALID = 1'b1;
    ID_INSTR = 32'h00100093;
    step();
    checks++; if (EX_CTRL !== ADDI_B || EX_RD !== 5'd1) begin errors++; $display("FAIL addi_ex got %h/%0d exp %h/1", EX_CTRL, EX_RD, ADDI_B); end
    ID_INSTR = 32'h00108113;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (STALL === 1'b1) ns++;
      if (n_stall === 1'b1) nn++;
      if (FWD && i == 1) begin
        checks++; if (FWD_A !== 2'b01 || FWD_B !== 2'b00) begin errors++; $display("FAIL raw_fwd got %b %b exp 01 00", FWD_A, FWD_B); end
      end
      step();
    end
    checks++; if (ns !== (FWD ? 0 : 2)) begin errors++; $display("FAIL raw_stalls_wt got %0d exp %0d", ns, FWD ? 0 : 2); end
    checks++; if (nn !== (FWD ? 0 : 3)) begin errors++; $display("FAIL raw_stalls_nwt got %0d exp %0d", nn, FWD ? 0 : 3); end
    idle(4);
  endtask

  task test_flush;
    ID_VALID = 1'b1;
    ID_INSTR = 32'h0000A283;
    step();
    ID_INSTR = 32'h00528333;
    EX_TAKEN = 1'b1;
    #1;
    checks++; if (FLUSH !== 1'b1 || STALL !== 1'b0) begin errors++; $display("FAIL flush_flags got %b%b exp 10", FLUSH, STALL); end
    step();
    checks++; if (EX_CTRL !== BUB || EX_RD !== 5'd0) begin errors++; $display("FAIL flush_ex got %h/%0d exp %h/0", EX_CTRL, EX_RD, BUB); end
    idle(4);
  endtask

  task test_store_illegal;
    ID_VALID = 1'b1;
    ID_INSTR = 32'h00208023;
    step();
    checks++; if (EX_CTRL !== SB_B || EX_RD !== 5'd0) begin errors++; $display("FAIL sb_ex got %h/%0d exp %h/0", EX_CTRL, EX_RD, SB_B); end
    checks++; if (ILLEGAL !== 1'b0) begin errors++; $display("FAIL sb_illegal got %b exp 0", ILLEGAL); end
    ID_INSTR = 32'hFFFFFFFF;
    step();
    checks++; if (EX_CTRL !== BUB || ILLEGAL !== 1'b1) begin errors++; $display("FAIL illegal got %h/%b exp %h/1", EX_CTRL, ILLEGAL, BUB); end
    ID_INSTR = 32'h002081B3;
    step();
    step();
    checks++; if (EX_CTRL !== ADD_B || ILLEGAL !== 1'b1) begin errors++; $display("FAIL illegal_sticky got %h/%b exp %h/1", EX_CTRL, ILLEGAL, ADD_B); end
  endtask

  task test_async_reset;
    #2;
    RSTn = 1'b0;
    #1;
    checks++; if (EX_CTRL !== BUB || MEM_CTRL !== BUB || WB_CTRL !== BUB) begin errors++; $display("FAIL async_reset got %h %h %h exp %h", EX_CTRL, MEM_CTRL, WB_CTRL, BUB); end
    checks++; if (ILLEGAL !== 1'b0 || STALL !== 1'b0 || EX_RD !== 5'd0) begin errors++; $display("FAIL async_reset_flags got %b%b/%0d exp 00/0", ILLEGAL, STALL, EX_RD); end
    ID_VALID = 1'b0;
    step();
    RSTn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_decode_alu();
    test_load_use();
    test_raw();
    test_flush();
    test_store_illegal();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Sequential successor to the pipeline decode block. Decodes the RV32I instruction held in IF/ID and carries the resulting control bundle through ID/EX, EX/MEM and MEM/WB registers. Detects RAW and load-use hazards, generates stall and flush, and tracks valid bits. Adds LUI/AUIPC, byte/half enables and illegal-opcode trapping. Sits beside the datapath in the 5-stage core; the top level uses STALL/FLUSH to hold PC and IF/ID.

Parameters:
REG_AW, 5, register index width
BE_W, 4, byte-enable width (>=4)
RF_WRITE_THROUGH, 1, 1 = RF write in WB is visible to same-cycle ID read, so no WB hazard
CTRL_W, 17+BE_W, packed bundle width (derived; do not override)

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  asynchronous active-low reset
ID_INSTR  in  32  instruction in ID stage
ID_VALID  in  1  ID_INSTR is valid
EX_TAKEN  in  1  branch/jump in EX resolved taken (redirect)
STALL  out  1  hold PC and IF/ID this cycle (combinational)
FLUSH  out  1  invalidate IF/ID this cycle (combinational, =EX_TAKEN)
EX_CTRL / MEM_CTRL / WB_CTRL  out  CTRL_W  registered bundle per stage
EX_RD / MEM_RD / WB_RD  out  REG_AW  destination register per stage
FWD_A, FWD_B  out  2  EX operand source: 00 RF, 01 EX/MEM, 10 MEM/WB
ILLEGAL  out  1  sticky: undefined opcode seen

Behaviour:
- Bundle bits: [0] valid, [1] rf_we, [3:2] op_src, [5:4] rw_src, [6] mem_read, [7] mem_wen (active-low), [7+BE_W:8] mem_be, then is_load, is_branch, is_jump, alu_src_b, alu_src_a, alu_op[3:0] in ascending order.
- Bubble: all bits 0 except mem_wen=1; RD=0.
- Decode by opcode:
  - JAL: src_a=0, src_b=1, jump, rw=00, we=1.
  - JALR: src_a=1, src_b=1, jump, rw=00, we=1.
  - BRANCH: alu_op={0,f3}, src_a=0, src_b=1, branch, op_src=10, we=0.
  - LOAD: src_a=1, src_b=1, load, mem_read=1, rw=01, we=1, be by f3[1:0].
  - STORE: src_a=1, src_b=1, mem_wen=0, op_src=01, we=0, be by f3[1:0].
  - OP-IMM: alu_op={f3==101 ? f7[5] : 0, f3}, src_a=1, src_b=1, rw=10, we=1.
  - OP: alu_op={f7[5], f3}, src_a=1, src_b=0, rw=10, we=1.
  - LUI: rw=11, we=1.
  - AUIPC: src_a=0, src_b=1, rw=10, we=1.
  - Other opcode: bubble, ILLEGAL<=1.
  - be: 00 -> 0001, 01 -> 0011, 10 -> 1111; upper bits 0.
- rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP. rs2 used by BRANCH, STORE, OP. x0 never hazards. rd is forced to 0 when we=0.
- Hazard (only when ID_VALID=1): a used rs matches the rd of a valid stage with rf_we=1.
  - No forwarding: match EX or MEM stalls; WB match stalls only if RF_WRITE_THROUGH=0.
  - Forwarding: stall only on an EX-stage load match.
- Each clock:
  - ID/EX <= bubble if FLUSH, STALL or !ID_VALID; else the decoded bundle.
  - EX/MEM <= ID/EX; MEM/WB <= EX/MEM (always shift).
- FLUSH has priority: when EX_TAKEN=1, STALL=0 and ID/EX takes a bubble.
- Reset (async, any time): all stages bubble, ILLEGAL=0. STALL=0, FLUSH=0, FWD=00 follow from the bubbled state. Outputs are valid immediately after RSTn rises.
- Latency: ID to EX bundle is 1 cycle.

Optional Feature:
PIPE_CTRL_FWD_EN
- Defined: forwarding hazard policy. FWD_A/FWD_B compare the EX instruction's rs1/rs2 against MEM_RD (->01, priority) then WB_RD (->10), requiring a valid rf_we source and rs!=0.
- Undefined: no-forwarding stall policy; FWD_A/FWD_B tied to 00.

Test Plan:
1. RSTn=0 mid-stream -> EX_CTRL=MEM_CTRL=WB_CTRL=21'h000080, STALL=0, ILLEGAL=0, asynchronously.
2. ID_INSTR=0x002081B3 (ADD x3,x1,x2) -> next cycle EX_CTRL alu_op=0000, src_b=0, rw=10, we=1, EX_RD=3. ID_INSTR=0x402081B3 (SUB) -> alu_op=1000. Bundle reaches WB_CTRL 2 cycles later.
3. 0x0000A283 (LW x5) then 0x00528333 (ADD x6,x5,x5):
   - With FWD_EN: 1 stall cycle; EX bubble; ADD then in EX with FWD_A=FWD_B=10.
   - Without FWD_EN: 2 stall cycles.
4. 0x00100093 (ADDI x1) then 0x00108113 (ADDI x2,x1,1):
   - No FWD, RF_WRITE_THROUGH=1: STALL 2 cycles.
   - RF_WRITE_THROUGH=0: STALL 3 cycles.
   - With FWD_EN: no stall; FWD_A=01.
5. EX_TAKEN=1 coincident with a load-use hazard -> FLUSH=1, STALL=0, EX_CTRL bubble next cycle.
6. 0x00208023 (SB) -> mem_be=0001, mem_wen=0, we=0. Then 0xFFFFFFFF -> EX bubble, ILLEGAL=1, held after later valid instructions until reset.
